oled_spi_tx: RTL and testbench

- Byte-stream SPI transmitter that drives the SSD1306-style OLED link: dc, serial clock and MOSI.
- The display receiver (vgaHdmi) decodes this same link.
- Used as a hardware test-pattern and loopback source for the video path, and as a soft replacement for the AVR SPI master when the CPU core is bypassed.
- Accepts {dc, byte} words over a valid/ready interface, buffers them in a FIFO and serialises them SPI mode 0, MSB first.

---
 rtl/oled_spi_tx_if.sv | 9 +
 rtl/oled_spi_tx.sv | 155 +++++++++++++++
 tb/tb_oled_spi_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/oled_spi_tx_if.sv
// oled_spi_tx_if: valid/ready word channel carrying {dc, byte} into the SPI transmitter.
interface oled_spi_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dc;
  modport master (output in_valid, in_data, in_dc, input in_ready);
  modport slave (input in_valid, in_data, in_dc, output in_ready);
endinterface

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: FIFO-buffered SPI mode 0 (MSB first) transmitter for an SSD1306-style OLED link.
// Define OLED_SPI_TX_CS_EN to add an active-low chip select with a CSHOLD tail.
module oled_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  oled_spi_tx_if.slave       s,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               busy,
  output logic               oled_dc,
  output logic               oled_clk,
  output logic               oled_data
`ifdef OLED_SPI_TX_CS_EN
  ,
  output logic               oled_cs_n
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef OLED_SPI_TX_CS_EN
  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, CSHOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH} state_t;
`endif
  state_t state_q, state_d;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] sh_q, sh_d;
  logic ready_q, busy_q, clk_q, clk_d, data_q, data_d, dc_q, dc_d;
  logic push, pop, tick, empty;
  logic [8:0] head;
`ifdef OLED_SPI_TX_CS_EN
  logic cs_q, cs_d;
  assign oled_cs_n = cs_q;
`endif
  assign push = s.in_valid & ready_q;
  assign empty = level_q == '0;
  assign head = mem[rd_q];
  assign tick = div_q == 8'(CLK_DIV - 1);
  assign wr_d = wr_q + AW'(push);
  assign rd_d = rd_q + AW'(pop);
  assign level_d = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
  always_ff @(posedge clk) if (push) mem[wr_q] <= {s.in_dc, s.in_data};
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    bit_d = bit_q;
    sh_d = sh_q;
    clk_d = clk_q;
    data_d = data_q;
    dc_d = dc_q;
    pop = 1'b0;
`ifdef OLED_SPI_TX_CS_EN
    cs_d = cs_q;
`endif
    case (state_q)
      IDLE: state_d = empty ? IDLE : LOAD;
      LOAD: begin
        pop = 1'b1;
        state_d = LOW;
      end
      LOW: begin
        div_d = tick ? '0 : div_q + 8'd1;
        clk_d = tick;
        state_d = tick ? HIGH : LOW;
      end
      HIGH: begin
        div_d = tick ? '0 : div_q + 8'd1;
        clk_d = !tick;
        if (tick) begin
          if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
            data_d = sh_q[6];
            sh_d = {sh_q[5:0], 1'b0};
            state_d = LOW;
          end else if (!empty) begin
            pop = 1'b1;
            state_d = LOW;
          end else begin
`ifdef OLED_SPI_TX_CS_EN
            state_d = CSHOLD;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef OLED_SPI_TX_CS_EN
      CSHOLD: begin
        div_d = tick ? '0 : div_q + 8'd1;
        cs_d = !empty ? cs_q : tick;
        state_d = !empty ? LOAD : (tick ? IDLE : CSHOLD);
      end
`endif
      default: state_d = IDLE;
    endcase
    // A pop loads the next byte's first bit on the same edge, giving gapless back-to-back bytes
    if (pop) begin
      dc_d = head[8];
      data_d = head[7];
      sh_d = head[6:0];
      bit_d = '0;
      div_d = '0;
`ifdef OLED_SPI_TX_CS_EN
      cs_d = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      clk_q <= 1'b0;
      data_q <= 1'b0;
      dc_q <= 1'b0;
`ifdef OLED_SPI_TX_CS_EN
      cs_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      ready_q <= level_d != LEVEL_W'(FIFO_DEPTH);
      busy_q <= (state_d != IDLE) | (level_d != '0);
      clk_q <= clk_d;
      data_q <= data_d;
      dc_q <= dc_d;
`ifdef OLED_SPI_TX_CS_EN
      cs_q <= cs_d;
`endif
    end
  end
  assign s.in_ready = ready_q;
  assign fifo_level = level_q;
  assign busy = busy_q;
  assign oled_clk = clk_q;
  assign oled_data = data_q;
  assign oled_dc = dc_q;
endmodule

// File: tb/tb_oled_spi_tx.sv
// tb_oled_spi_tx: directed and randomized checks of oled_spi_tx (CLK_DIV=4, FIFO_DEPTH=16).
module tb_oled_spi_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  oled_spi_tx_if bus();
  logic [4:0] fifo_level;
  logic busy, oled_dc, oled_clk, oled_data;
`ifdef OLED_SPI_TX_CS_EN
  logic oled_cs_n;
`endif
  oled_spi_tx #(.CLK_DIV(4), .FIFO_DEPTH(16), .LEVEL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus), .fifo_level(fifo_level), .busy(busy),
    .oled_dc(oled_dc), .oled_clk(oled_clk), .oled_data(oled_data)
`ifdef OLED_SPI_TX_CS_EN
    , .oled_cs_n(oled_cs_n)
`endif
  );
  int tn = 0, tf = 0, rises = 0, viol = 0, nb = 0;
  logic [7:0] sh = '0;
  logic pclk = 0, pdat = 0, pdc = 0, last_d = 0, last_dc = 0;
  logic [8:0] rx[$];
  // Receiver-side monitor: samples MOSI on rising serial clock, frames bytes with dc
  always @(negedge clk) begin
    if (!rst_n) nb <= 0;
    else if (oled_clk && !pclk) begin
      rises <= rises + 1;
      sh <= {sh[6:0], oled_data};
      if (nb == 7) begin
        rx.push_back({oled_dc, sh[6:0], oled_data});
        nb <= 0;
      end else nb <= nb + 1;
    end
    if (pclk && oled_clk && (oled_data != pdat || oled_dc != pdc)) viol <= viol + 1;
    pclk <= oled_clk;
    pdat <= oled_data;
    pdc <= oled_dc;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tn++;
    assert (got === exp) else begin
      tf++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Expected {ready, level, busy, dc, data, clk} after edge k when w is pushed on edges 0..n-1
  function automatic logic [9:0] expv(input int k, input logic [8:0] w[$], input logic pd, input logic pdc0);
    int n = w.size();
    int e = 2 + 64 * n;
    int p = k - 2;
    int lvl;
    logic c = 1'b0, d = pd, dc = pdc0;
    if (k >= e) begin
      d = w[n-1][0];
      dc = w[n-1][8];
    end else if (k >= 2) begin
      d = w[p/64][7-(p%64)/8];
      dc = w[p/64][8];
      c = (p % 8) >= 4;
    end
    lvl = ((k + 1 < n) ? k + 1 : n) - ((k < 2) ? 0 : ((p / 64 + 1 < n) ? p / 64 + 1 : n));
    return {lvl != 16, 5'(lvl), k < e, dc, d, c};
  endfunction
  task automatic run(input logic [8:0] w[$], input string nm);
    int n = w.size();
    int e = 2 + 64 * n;
    rx.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    {bus.in_dc, bus.in_data} = w[0];
    for (int k = 0; k < e + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k + 1 < n) {bus.in_dc, bus.in_data} = w[k+1];
      else bus.in_valid = 1'b0;
      chk($sformatf("%s_c%0d", nm, k), {bus.in_ready, fifo_level, busy, oled_dc, oled_data, oled_clk},
          expv(k, w, last_d, last_dc));
    end
    chk({nm, "_count"}, rx.size(), n);
    for (int i = 0; i < n && i < rx.size(); i++) chk($sformatf("%s_rx%0d", nm, i), rx[i], w[i]);
    last_d = w[n-1][0];
    last_dc = w[n-1][8];
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [8:0] w[$];
    int e, r0;
    logic acc;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_dc = 1'b0;
    #2;
    chk("reset", {bus.in_ready, fifo_level, busy, oled_dc, oled_data, oled_clk}, 10'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", bus.in_ready, 1);
    w = '{9'h0A5};
    run(w, "single");
    w = '{9'h0AF, 9'h13C};
    run(w, "b2b");
    for (int r = 0; r < 3; r++) begin
      w.delete();
      repeat ($urandom_range(1, 17)) w.push_back(9'($urandom));
      run(w, $sformatf("rand%0d", r));
    end
    // Backpressure: 17 words fill shifter and FIFO, the 18th waits for the first pop after byte 0
    rx.delete();
    w.delete();
    repeat (18) w.push_back(9'($urandom));
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      {bus.in_dc, bus.in_data} = w[i];
      @(posedge clk);
    end
    @(negedge clk);
    chk("bp_ready", bus.in_ready, 0);
    chk("bp_level", fifo_level, 16);
    {bus.in_dc, bus.in_data} = w[17];
    e = 16;
    acc = 1'b0;
    while (!acc && e < 300) begin
      acc = bus.in_ready;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("bp_accept_edge", e, 67);
    for (int c = 0; c < 2000 && busy; c++) @(negedge clk);
    chk("bp_drained", busy, 0);
    chk("bp_count", rx.size(), 18);
    for (int i = 0; i < 18 && i < rx.size(); i++) chk($sformatf("bp_rx%0d", i), rx[i], w[i]);
    // Reset during bit 3 with more words queued
    rx.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      {bus.in_dc, bus.in_data} = 9'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_clk_high", oled_clk, 1);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset", {bus.in_ready, fifo_level, busy, oled_data, oled_clk}, 9'h0);
    r0 = rises;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("post_reset_rises", rises, r0);
    chk("post_reset_rx", rx.size(), 0);
    chk("post_reset_state", {bus.in_ready, fifo_level, busy, oled_clk}, 8'h80);
    chk("stable_while_high", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tn, tf);
    $finish;
  end
endmodule
